// File: rtl/pio_input_edge.sv
// Avalon-MM input PIO: per-bit synchroniser, debounce filter,
// sticky edge capture with interrupt mask and level IRQ.
module pio_input_edge #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         irqmask_q, irqmask_d;
  logic [WIDTH-1:0]         edgecap_q, edgecap_d;
  logic [31:0]              readdata_q, readdata_d;
  logic                     irq_q, irq_d;

  logic [WIDTH-1:0] rise, fall, evt, clr;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en = chipselect & ~write_n;

  // Debounce: a bit must differ from stable for DEBOUNCE_CYCLES edges
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rise = stable_d & ~stable_q;
    fall = ~stable_d & stable_q;
    if (EDGE_TYPE == 0)      evt = rise;
    else if (EDGE_TYPE == 1) evt = fall;
    else                     evt = rise | fall;
  end

  // New events override a simultaneous write-1-to-clear
  always_comb begin
    irqmask_d = irqmask_q;
    clr       = '0;
    if (wr_en) begin
      unique case (address)
        2'd2:    irqmask_d = writedata[WIDTH-1:0];
        2'd3:    clr       = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    edgecap_d = (edgecap_q & ~clr) | evt;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd2:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_input_edge.sv
// Directed bench for pio_input_edge: three instances, one per
// capture mode, sharing the bus and inputs (DEBOUNCE_CYCLES=8).
module tb_pio_input_edge;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int vectors = 0;
  int errs    = 0;

  pio_input_edge #(.WIDTH(10), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .irq(irq0)
  );

  pio_input_edge #(.WIDTH(10), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1),
    .in_port(in_port), .irq(irq1)
  );

  pio_input_edge #(.WIDTH(10), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd2),
    .in_port(in_port), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 10'h3FF;

    // Reset and first qualification of an all-ones input
    cyc(3);
    chk("rst_rd", rd2, 32'h0);
    chk("rst_irq", {31'b0, irq2}, 32'h0);
    reset_n = 1'b1;
    cyc(10);
    chk("data_pre", rd2, 32'h0);
    cyc(1);
    chk("data_3ff", rd2, 32'h3FF);
    address = 2'd3;
    cyc(1);
    chk("ec_any_3ff", rd2, 32'h3FF);
    chk("ec_rise_3ff", rd0, 32'h3FF);
    chk("ec_fall_0", rd1, 32'h0);

    in_port = 10'h000;
    cyc(12);
    wr(2'd3, 32'h3FF);
    cyc(1);
    chk("ec_clr", rd2, 32'h0);
    chk("ec_clr_fall", rd1, 32'h0);

    // Debounce: a 5-cycle pulse is filtered
    address = 2'd0;
    in_port = 10'h001;
    cyc(5);
    in_port = 10'h000;
    cyc(15);
    chk("glitch_data", rd2, 32'h0);
    address = 2'd3;
    cyc(1);
    chk("glitch_ec", rd2, 32'h0);

    // Held input appears 10 edges after change (+1 read)
    address = 2'd0;
    in_port = 10'h001;
    cyc(10);
    chk("deb_pre", rd2, 32'h0);
    cyc(1);
    chk("deb_data", rd2, 32'h1);
    address = 2'd3;
    cyc(1);
    chk("deb_ec", rd2, 32'h1);
    wr(2'd3, 32'h3FF);

    // Edge modes: pulse on bit 3
    in_port = 10'h009;
    cyc(12);
    chk("rise_m0", rd0, 32'h008);
    chk("rise_m1", rd1, 32'h000);
    chk("rise_m2", rd2, 32'h008);
    in_port = 10'h001;
    cyc(12);
    chk("fall_m0", rd0, 32'h008);
    chk("fall_m1", rd1, 32'h008);
    chk("fall_m2", rd2, 32'h008);
    wr(2'd3, 32'h3FF);
    cyc(1);
    chk("mode_clr", rd2, 32'h0);

    // IRQ and mask timing
    wr(2'd2, 32'h008);
    cyc(1);
    chk("mask_rd", rd2, 32'h008);
    address = 2'd3;
    in_port = 10'h009;
    cyc(10);
    chk("irq_pre", {31'b0, irq2}, 32'h0);
    cyc(1);
    chk("irq_set", {31'b0, irq2}, 32'h1);
    chk("irq_ec", rd2, 32'h008);
    chk("irq_m1", {31'b0, irq1}, 32'h0);
    wr(2'd3, 32'h008);
    chk("irq_hold", {31'b0, irq2}, 32'h1);
    cyc(1);
    chk("irq_clr", {31'b0, irq2}, 32'h0);
    chk("irq_clr_ec", rd2, 32'h0);
    in_port = 10'h019;
    cyc(12);
    chk("unmask_ec", rd2, 32'h010);
    chk("unmask_irq", {31'b0, irq2}, 32'h0);

    // Clear collides with a new bit-2 event
    wr(2'd2, 32'h004);
    in_port = 10'h01D;
    cyc(12);
    chk("col_irq_pre", {31'b0, irq2}, 32'h1);
    in_port = 10'h019;
    cyc(9);
    wr(2'd3, 32'h004);
    cyc(1);
    chk("col_ec", rd2, 32'h014);
    chk("col_irq", {31'b0, irq2}, 32'h1);
    chk("col_ec_m0", rd0, 32'h010);
    chk("col_irq_m0", {31'b0, irq0}, 32'h0);

    // Address map and upper-bit masking
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    address = 2'd1;
    cyc(1);
    chk("map_a1", rd2, 32'h0);
    address = 2'd0;
    cyc(1);
    chk("map_a0", rd2, 32'h019);
    address = 2'd2;
    cyc(1);
    chk("map_a2", rd2, 32'h004);
    address = 2'd3;
    cyc(1);
    chk("map_a3", rd2, 32'h014);
    wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    cyc(1);
    chk("map_mask_w", rd2, 32'h3FF);
    chk("map_irq", {31'b0, irq2}, 32'h1);

    // Asynchronous reset mid-run, then re-qualification
    address = 2'd3;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rd", rd2, 32'h0);
    chk("arst_irq", {31'b0, irq2}, 32'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    chk("requal_pre", rd2, 32'h0);
    cyc(1);
    chk("requal_ec", rd2, 32'h019);
    chk("requal_irq", {31'b0, irq2}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/pio_input_edge.md
Name: pio_input_edge

Overview:
Parametrised Avalon-MM input PIO slave, successor to the plain switch/button input port. Each input bit passes through a 2-flop synchroniser and a per-bit debounce filter. The block keeps a sticky edge-capture register with a per-bit interrupt mask and drives a level IRQ to the CPU. It sits between board switches/buttons and the Nios II system interconnect.

Parameters:
WIDTH, 10, number of input bits (1..32)
DEBOUNCE_CYCLES, 1000, consecutive stable clk cycles required before a bit change is accepted (1..65535)
EDGE_TYPE, 2, capture mode: 0 = rising, 1 = falling, 2 = any edge

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data; bits above WIDTH ignored
readdata  output  32  registered read data; bits above WIDTH read 0
in_port  input  WIDTH  raw asynchronous inputs
irq  output  1  level interrupt request

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state is flopped on posedge clk and cleared on negedge reset_n.
- Reset values:
  - readdata = 0, irq = 0.
  - Synchroniser flops = 0, debounce counters = 0, stable data = 0, irqmask = 0, edgecapture = 0.
- Synchroniser: sync1 <= in_port; sync2 <= sync1. A change on in_port reaches sync2 two edges later.
- Debounce, per bit i:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE_CYCLES-1 on an edge, stable[i] <= sync2[i] and cnt[i] <= 0.
  - Any glitch back to the stable value before the count completes restarts the count from 0.
  - Counter width = clog2(DEBOUNCE_CYCLES)+1; counters never wrap.
  - Total latency from in_port change to stable change = 2 + DEBOUNCE_CYCLES edges.
- Edge detect, per bit: an event fires on the edge where stable[i] changes.
  - Mode 0 captures 0->1 transitions, mode 1 captures 1->0, mode 2 captures both.
- Register map (word addresses):
  - 0 = DATA: stable[WIDTH-1:0], read-only.
  - 1 = reserved, reads 0.
  - 2 = IRQMASK: read/write.
  - 3 = EDGECAPTURE: read; write-1-to-clear.
- Reads: readdata <= mux(address) on every clk edge, independent of chipselect. Read latency is 1 cycle.
- Writes: occur when chipselect == 1 and write_n == 0.
  - IRQMASK <= writedata[WIDTH-1:0].
  - EDGECAPTURE[i] <= 0 where writedata[i] == 1.
  - Writes to addresses 0 and 1 are ignored.
- Simultaneous clear and new event on the same bit in the same cycle: the set wins and the bit stays 1.
- EDGECAPTURE bits are sticky until cleared by software or reset.
- irq <= |(EDGECAPTURE & IRQMASK), registered. irq follows a capture or mask change by 1 cycle and deasserts 1 cycle after the clearing write.
- Reset asserted mid-debounce or mid-transaction: all state clears immediately. After release, a held input is re-qualified from cnt = 0, so it produces an edge event once it is stable again.

Test Plan:
- Reset/idle: hold reset_n=0 with in_port=10'h3FF, then release. Required: readdata=0 and irq=0 during reset. DATA reads 10'h3FF at edge 2+DEBOUNCE_CYCLES(+1 read) after release. With EDGE_TYPE=2, EDGECAPTURE reads 10'h3FF.
- Debounce filtering (DEBOUNCE_CYCLES=8): toggle in_port[0] high for 5 cycles, then low. Required: DATA stays 0 and EDGECAPTURE stays 0. Then hold high for 20 cycles. Required: DATA[0]=1 exactly 10 edges after the change.
- Edge modes: run a 0->1->0 pulse on bit 3, one pass per EDGE_TYPE. Required EDGECAPTURE[3]: mode 0 sets on the rise only, mode 1 on the fall only, mode 2 on both; the bit remains set until cleared.
- IRQ/mask: IRQMASK=10'h008 with a bit-3 edge. Required: irq=1 one cycle after capture. Writing 0x008 to address 3 gives irq=0 one cycle later. An edge on bit 4 with mask bit 4 = 0 sets EDGECAPTURE[4] but leaves irq=0.
- Clear/set collision: write 1 to EDGECAPTURE[2] in the same cycle a new bit-2 event fires. Required: bit 2 reads 1 and irq stays 1.
- Address map: write 0xFFFFFFFF to addresses 0 and 1. Required: no state change, address 1 reads 0, and bits [31:WIDTH] read 0 at every address.
